// File: rtl/mc_mem_bridge_pkg.sv
// Shared definitions for the CPU-to-memory bridge: FSM state encodings, error codes
// and the default poison value returned on a failed read.
package mc_mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_CONFLICT = 2'b11;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/mc_mem_bridge_timeout_cnt.sv
// Wait-state counter for the memory bridge. Holds at TIMEOUT-1 and flags expiry there;
// TIMEOUT=0 disables expiry entirely.
module mc_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
      assign expire = (cnt_q == LAST);
    end
  endgenerate

  // Stops at the expiry value so the count can never wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expire) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/mc_mem_bridge.sv
// Bridges the multi-cycle CPU's held MemRd/MemWr strobes to a req/ack memory with
// variable latency, stalling the CPU until the access has completed or failed.
import mc_mem_bridge_pkg::*;

module mc_mem_bridge #(
  parameter int              AW       = 32,
  parameter int              DW       = 32,
  parameter int              TIMEOUT  = 255,
  parameter logic [DW-1:0]   ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  output logic          cpu_err,
  output logic [1:0]    err_code,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    dbg_state
);

  // Memory handshake: mem_req rises on BUSY entry and stays high with mem_we, mem_addr and
  // mem_wdata frozen until the cycle mem_ack is sampled high (or the wait budget runs out);
  // mem_ack carries mem_rdata in that same cycle and is ignored in any other state.

  state_t        state_q, state_d;
  logic [1:0]    err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;
  logic          latch;
  logic          access;
  logic          expire;

  assign access = cpu_rd | cpu_wr;

  mc_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (state_q != ST_BUSY),
    .enable (state_q == ST_BUSY),
    .expire (expire)
  );

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    latch     = 1'b0;
    cpu_stall = 1'b0;
    mem_req   = 1'b0;
    cpu_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cpu_stall = access;
        // Conflict outranks misalignment; neither error ever reaches the memory.
        if (cpu_rd && cpu_wr) begin
          state_d = ST_DONE;
          err_d   = ERR_CONFLICT;
        end else if (access && is_misaligned(cpu_addr[1:0])) begin
          state_d = ST_DONE;
          err_d   = ERR_MISALIGN;
        end else if (access) begin
          state_d = ST_BUSY;
          latch   = 1'b1;
        end
      end
      ST_BUSY: begin
        mem_req   = 1'b1;
        cpu_stall = 1'b1;
        if (mem_ack) begin
          state_d = ST_DONE;
          err_d   = ERR_NONE;
          if (!we_q) rdata_d = mem_rdata;
        end else if (expire) begin
          state_d = ST_DONE;
          err_d   = ERR_TIMEOUT;
          if (!we_q) rdata_d = ERR_DATA;
        end
      end
      ST_DONE: begin
        cpu_err = (err_q != ERR_NONE);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_NONE;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (latch) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        we_q    <= cpu_wr;
      end
    end
  end

  assign cpu_rdata = rdata_q;
  assign err_code  = err_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mc_mem_bridge.sv
// Directed bench for mc_mem_bridge: reads, writes with wait states, error accesses,
// timeout and ack-at-deadline, back-to-back accesses and mid-transaction reset.
module tb_mc_mem_bridge;

  logic        clk;
  logic        reset;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_err;
  logic [1:0]  err_code;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  mc_mem_bridge #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .cpu_err   (cpu_err),
    .err_code  (err_code),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick; tick;
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b exp 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b exp 0", mem_we); end
    checks++; if (cpu_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b exp 0", cpu_err); end
    checks++; if (err_code !== 2'b00) begin failures++; $display("FAIL reset_code: got %b exp 00", err_code); end
    checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h exp 0", cpu_rdata); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_addr_wdata: got %h/%h exp 0/0", mem_addr, mem_wdata); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b exp 0", cpu_stall); end
    reset = 1'b1;
    tick;
  endtask

  task automatic test_read;
    cpu_rd = 1'b1; cpu_addr = 32'h40;
    #1;
    checks++; if (cpu_stall !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL read_idle: stall %b req %b exp 1 0", cpu_stall, mem_req); end
    tick;
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40 || cpu_stall !== 1'b1) begin failures++; $display("FAIL read_busy: req %b we %b addr %h stall %b exp 1 0 40 1", mem_req, mem_we, mem_addr, cpu_stall); end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick;
    mem_ack = 1'b0; mem_rdata = '0;
    checks++; if (cpu_stall !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL read_done: stall %b req %b exp 0 0", cpu_stall, mem_req); end
    checks++; if (cpu_rdata !== 32'h1234_5678) begin failures++; $display("FAIL read_data: got %h exp 12345678", cpu_rdata); end
    checks++; if (err_code !== 2'b00 || cpu_err !== 1'b0) begin failures++; $display("FAIL read_err: code %b err %b exp 00 0", err_code, cpu_err); end
    cpu_rd = 1'b0;
    tick;
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL read_back_idle: got %0d exp 0", dbg_state); end
  endtask

  task automatic test_write_waits;
    int stall_cycles = 0;
    cpu_wr = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'hA5A5_A5A5;
    #1;
    if (cpu_stall) stall_cycles++;
    tick;
    for (int i = 0; i < 5; i++) begin
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL write_busy%0d: req %b we %b addr %h wdata %h", i, mem_req, mem_we, mem_addr, mem_wdata); end
      if (cpu_stall) stall_cycles++;
      cpu_wdata = 32'h0; cpu_addr = 32'hFFFC;
      if (i == 4) begin mem_ack = 1'b1; mem_rdata = 32'h7777_7777; end
      tick;
    end
    mem_ack = 1'b0; mem_rdata = '0;
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL write_done_stall: got %b exp 0", cpu_stall); end
    checks++; if (stall_cycles != 6) begin failures++; $display("FAIL write_stall_count: got %0d exp 6", stall_cycles); end
    checks++; if (cpu_rdata !== 32'h1234_5678) begin failures++; $display("FAIL write_rdata_kept: got %h exp 12345678", cpu_rdata); end
    checks++; if (err_code !== 2'b00 || cpu_err !== 1'b0) begin failures++; $display("FAIL write_err: code %b err %b exp 00 0", err_code, cpu_err); end
    cpu_wr = 1'b0;
    tick;
  endtask

  task automatic test_misaligned;
    cpu_rd = 1'b1; cpu_addr = 32'h42;
    #1;
    checks++; if (cpu_stall !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL mis_idle: stall %b req %b exp 1 0", cpu_stall, mem_req); end
    tick;
    checks++; if (dbg_state !== 2'd2 || mem_req !== 1'b0 || cpu_stall !== 1'b0) begin failures++; $display("FAIL mis_done: state %0d req %b stall %b exp 2 0 0", dbg_state, mem_req, cpu_stall); end
    checks++; if (cpu_err !== 1'b1 || err_code !== 2'b01) begin failures++; $display("FAIL mis_err: err %b code %b exp 1 01", cpu_err, err_code); end
    checks++; if (cpu_rdata !== 32'h1234_5678) begin failures++; $display("FAIL mis_rdata: got %h exp 12345678", cpu_rdata); end
    cpu_rd = 1'b0;
    tick;
    checks++; if (cpu_err !== 1'b0 || err_code !== 2'b01) begin failures++; $display("FAIL mis_sticky: err %b code %b exp 0 01", cpu_err, err_code); end
  endtask

  task automatic test_conflict;
    cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h43;
    tick;
    checks++; if (mem_req !== 1'b0 || dbg_state !== 2'd2) begin failures++; $display("FAIL conf_done: req %b state %0d exp 0 2", mem_req, dbg_state); end
    checks++; if (cpu_err !== 1'b1 || err_code !== 2'b11) begin failures++; $display("FAIL conf_err: err %b code %b exp 1 11", cpu_err, err_code); end
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    tick;
    checks++; if (cpu_err !== 1'b0) begin failures++; $display("FAIL conf_pulse: got %b exp 0", cpu_err); end
  endtask

  task automatic test_timeout;
    int req_cycles = 0;
    cpu_rd = 1'b1; cpu_addr = 32'h100;
    tick;
    for (int i = 0; i < 20 && mem_req === 1'b1; i++) begin
      req_cycles++;
      tick;
    end
    checks++; if (req_cycles != 8) begin failures++; $display("FAIL to_req_cycles: got %0d exp 8", req_cycles); end
    checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL to_rdata: got %h exp deadbeef", cpu_rdata); end
    checks++; if (err_code !== 2'b10 || cpu_err !== 1'b1 || cpu_stall !== 1'b0) begin failures++; $display("FAIL to_err: code %b err %b stall %b exp 10 1 0", err_code, cpu_err, cpu_stall); end
    cpu_rd = 1'b0;
    tick;
  endtask

  task automatic test_ack_at_deadline;
    cpu_rd = 1'b1; cpu_addr = 32'h104;
    tick;
    for (int i = 0; i < 7; i++) tick;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL dl_req8: got %b exp 1", mem_req); end
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0008;
    tick;
    mem_ack = 1'b0; mem_rdata = '0;
    checks++; if (cpu_rdata !== 32'hCAFE_0008) begin failures++; $display("FAIL dl_rdata: got %h exp cafe0008", cpu_rdata); end
    checks++; if (err_code !== 2'b00 || cpu_err !== 1'b0) begin failures++; $display("FAIL dl_err: code %b err %b exp 00 0", err_code, cpu_err); end
    cpu_rd = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    cpu_rd = 1'b1; cpu_addr = 32'h10;
    tick;
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick;
    mem_ack = 1'b0; mem_rdata = '0;
    checks++; if (cpu_rdata !== 32'h1111_1111 || dbg_state !== 2'd2) begin failures++; $display("FAIL b2b_first: rdata %h state %0d exp 11111111 2", cpu_rdata, dbg_state); end
    cpu_addr = 32'h14;
    tick;
    checks++; if (dbg_state !== 2'd0 || cpu_stall !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL b2b_idle: state %0d stall %b req %b exp 0 1 0", dbg_state, cpu_stall, mem_req); end
    tick;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h14) begin failures++; $display("FAIL b2b_busy: req %b addr %h exp 1 14", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    tick;
    mem_ack = 1'b0; mem_rdata = '0;
    checks++; if (cpu_rdata !== 32'h2222_2222) begin failures++; $display("FAIL b2b_second: got %h exp 22222222", cpu_rdata); end
    cpu_rd = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    cpu_rd = 1'b1; cpu_addr = 32'h200;
    tick; tick; tick;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rm_busy3: got %b exp 1", mem_req); end
    reset = 1'b0; cpu_rd = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || dbg_state !== 2'd0 || mem_addr !== 32'h0) begin failures++; $display("FAIL rm_drop: req %b state %0d addr %h exp 0 0 0", mem_req, dbg_state, mem_addr); end
    tick;
    reset = 1'b1;
    tick;
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    tick;
    mem_ack = 1'b0; mem_rdata = '0;
    checks++; if (dbg_state !== 2'd0 || mem_req !== 1'b0 || cpu_rdata !== 32'h0 || err_code !== 2'b00) begin failures++; $display("FAIL rm_stray_ack: state %0d req %b rdata %h code %b exp 0 0 0 00", dbg_state, mem_req, cpu_rdata, err_code); end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write_waits;
    test_misaligned;
    test_conflict;
    test_timeout;
    test_ack_at_deadline;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
